// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - multi-cycle chunked add/subtract unit with flags (optional saturation: ADDSUB_SAT_EN)
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
`ifdef ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cf,
    output logic             ovf,
    output logic             sf,
    output logic             zf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("addsub_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             zacc;
    logic             is_sub;
    logic             a_msb;
    logic             bp_msb;
    logic             sat_q;

    logic             accept;
    logic             last;
    logic [CHUNK:0]   slice_add;
    logic [WIDTH-1:0] raw_sum;
    logic             raw_msb;
    logic             raw_ovf;
    logic             clamp;
    logic [WIDTH-1:0] clamp_val;

    assign accept = (state == IDLE) && in_valid;
    assign last   = (cnt == CW'(N - 1));

    // One CHUNK-bit adder shared across all slices; the operands shift down so the active slice is always at bit 0.
    assign slice_add = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};

    // On the final slice the full result is the new top slice above the slices already shifted into work.
    assign raw_sum   = WIDTH'({slice_add[CHUNK-1:0], work} >> CHUNK);
    assign raw_msb   = slice_add[CHUNK-1];
    assign raw_ovf   = (a_msb ^ raw_msb) & (bp_msb ^ raw_msb);
    assign clamp     = sat_q & raw_ovf;
    assign clamp_val = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch and slice-by-slice accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            work   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            zacc   <= 1'b0;
            is_sub <= 1'b0;
            a_msb  <= 1'b0;
            bp_msb <= 1'b0;
            sat_q  <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= op[0] ? ~b : b;
            work   <= '0;
            cnt    <= '0;
            carry  <= op[1] ? (cin ^ op[0]) : op[0];
            zacc   <= 1'b0;
            is_sub <= op[0];
            a_msb  <= a[WIDTH-1];
            bp_msb <= op[0] ? ~b[WIDTH-1] : b[WIDTH-1];
`ifdef ADDSUB_SAT_EN
            sat_q  <= sat;
`else
            sat_q  <= 1'b0;
`endif
        end else if (state == BUSY) begin
            a_sh  <= a_sh >> CHUNK;
            b_sh  <= b_sh >> CHUNK;
            work  <= raw_sum;
            cnt   <= cnt + CW'(1);
            carry <= slice_add[CHUNK];
            zacc  <= zacc | (|slice_add[CHUNK-1:0]);
        end
    end

    // Result and flags update only on the final slice, so they hold through DONE and after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            cf  <= 1'b0;
            ovf <= 1'b0;
            sf  <= 1'b0;
            zf  <= 1'b0;
        end else if (state == BUSY && last) begin
            sum <= clamp ? clamp_val : raw_sum;
            cf  <= slice_add[CHUNK] ^ is_sub;
            ovf <= raw_ovf;
            sf  <= clamp ? a_msb : raw_msb;
            zf  <= clamp ? 1'b0 : ~(zacc | (|slice_add[CHUNK-1:0]));
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - directed self-checking bench for addsub_seq
`timescale 1ns/1ps
module tb_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        cin;
`ifdef ADDSUB_SAT_EN
    logic        sat;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cf;
    logic        ovf;
    logic        sf;
    logic        zf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin),
`ifdef ADDSUB_SAT_EN
        .sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cf(cf), .ovf(ovf), .sf(sf), .zf(zf)
    );

    // Present one operation in IDLE, return the number of cycles from accept to out_valid (99 on timeout).
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic [1:0] opv,
                            input logic cv, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        a = av; b = bv; op = opv; cin = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if ({sum, cf, ovf, sf, zf} !== 20'h0) begin errors++; $display("FAIL reset_outputs got %h/%b%b%b%b exp 0", sum, cf, ovf, sf, zf); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_overflow();
        int lat;
        start_op(16'h7FFF, 16'h0001, 2'b00, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got %0d exp 4", lat); end
        checks++; if ({sum, cf, ovf, sf, zf} !== {16'h8000, 4'b0110}) begin errors++; $display("FAIL add_ovf got %h cf%b ovf%b sf%b zf%b exp 8000 0 1 1 0", sum, cf, ovf, sf, zf); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready got %b exp 0", in_ready); end
        handshake();
        checks++; if (out_valid !== 1'b0 || sum !== 16'h8000) begin errors++; $display("FAIL post_hs got ov%b sum %h exp 0 8000", out_valid, sum); end
    endtask

    task automatic test_sub();
        int lat;
        start_op(16'h0000, 16'h0001, 2'b01, 1'b1, lat);
        checks++; if ({sum, cf, ovf, sf, zf} !== {16'hFFFF, 4'b1010}) begin errors++; $display("FAIL sub_borrow got %h cf%b ovf%b sf%b zf%b exp FFFF 1 0 1 0", sum, cf, ovf, sf, zf); end
        handshake();
        start_op(16'h1234, 16'h1234, 2'b01, 1'b0, lat);
        checks++; if ({sum, cf, ovf, sf, zf} !== {16'h0000, 4'b0001}) begin errors++; $display("FAIL sub_zero got %h cf%b ovf%b sf%b zf%b exp 0000 0 0 0 1", sum, cf, ovf, sf, zf); end
        handshake();
    endtask

    task automatic test_carry_chain();
        int lat;
        start_op(16'hFFFF, 16'h0000, 2'b10, 1'b1, lat);
        checks++; if ({sum, cf, ovf, sf, zf} !== {16'h0000, 4'b1001}) begin errors++; $display("FAIL adc got %h cf%b ovf%b sf%b zf%b exp 0000 1 0 0 1", sum, cf, ovf, sf, zf); end
        handshake();
        start_op(16'h0000, 16'h0000, 2'b11, 1'b1, lat);
        checks++; if ({sum, cf, ovf, sf, zf} !== {16'hFFFF, 4'b1010}) begin errors++; $display("FAIL sbb got %h cf%b ovf%b sf%b zf%b exp FFFF 1 0 1 0", sum, cf, ovf, sf, zf); end
        handshake();
        start_op(16'h0005, 16'h0003, 2'b10, 1'b0, lat);
        checks++; if (sum !== 16'h0008 || cf !== 1'b0) begin errors++; $display("FAIL adc_cin0 got %h cf%b exp 0008 0", sum, cf); end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(16'h0010, 16'h0020, 2'b00, 1'b0, lat);
        a = 16'h1111; b = 16'h1111; op = 2'b00; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h0030 || {cf, ovf, sf, zf} !== 4'b0000) begin
                errors++; $display("FAIL bp_hold cyc%0d got ov%b ir%b sum %h flags %b%b%b%b exp 1 0 0030 0000", i, out_valid, in_ready, sum, cf, ovf, sf, zf);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got ov%b ir%b exp 0 1", out_valid, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
        checks++; if (lat !== 4 || sum !== 16'h2222) begin errors++; $display("FAIL bp_next got lat %0d sum %h exp 4 2222", lat, sum); end
        handshake();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        a = 16'h00FF; b = 16'h0001; op = 2'b00; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || {sum, cf, ovf, sf, zf} !== 20'h0) begin
            errors++; $display("FAIL rst_mid got ir%b ov%b sum %h flags %b%b%b%b exp 1 0 0000 0000", in_ready, out_valid, sum, cf, ovf, sf, zf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_after cyc%0d got ir%b ov%b exp 1 0", i, in_ready, out_valid); end
        end
        start_op(16'h0003, 16'h0004, 2'b00, 1'b0, lat);
        checks++; if (lat !== 4 || sum !== 16'h0007) begin errors++; $display("FAIL rst_fresh got lat %0d sum %h exp 4 0007", lat, sum); end
        handshake();
    endtask

`ifdef ADDSUB_SAT_EN
    task automatic test_saturation();
        int lat;
        sat = 1'b1;
        start_op(16'h7FFF, 16'h0001, 2'b00, 1'b0, lat);
        checks++; if ({sum, cf, ovf, sf, zf} !== {16'h7FFF, 4'b0100} || lat !== 4) begin errors++; $display("FAIL sat_pos got %h cf%b ovf%b sf%b zf%b lat %0d exp 7FFF 0 1 0 0 4", sum, cf, ovf, sf, zf, lat); end
        handshake();
        start_op(16'h8000, 16'h0001, 2'b01, 1'b0, lat);
        checks++; if ({sum, cf, ovf, sf, zf} !== {16'h8000, 4'b0110}) begin errors++; $display("FAIL sat_neg got %h cf%b ovf%b sf%b zf%b exp 8000 0 1 1 0", sum, cf, ovf, sf, zf); end
        handshake();
        sat = 1'b0;
        start_op(16'h7FFF, 16'h0001, 2'b00, 1'b0, lat);
        checks++; if (sum !== 16'h8000 || ovf !== 1'b1) begin errors++; $display("FAIL sat_off got %h ovf%b exp 8000 1", sum, ovf); end
        handshake();
    endtask
`endif

    initial begin
        in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = 2'b00; cin = 1'b0;
`ifdef ADDSUB_SAT_EN
        sat = 1'b0;
`endif
        test_reset();
        test_add_overflow();
        test_sub();
        test_carry_chain();
        test_backpressure();
        test_reset_mid_op();
`ifdef ADDSUB_SAT_EN
        test_saturation();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Multi-cycle, parametrised add/subtract unit with status flags (carry/borrow, signed overflow, sign, zero).
- Processes a WIDTH-bit operation one CHUNK-bit slice per cycle, LSB first, through a single CHUNK-bit adder.
- Supports add, subtract, add-with-carry and subtract-with-borrow for multi-word arithmetic.
- Sits between an operand source and a result consumer, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, operand/result width in bits
CHUNK, 4, adder slice width per cycle; WIDTH must be an integer multiple of CHUNK and CHUNK ≤ WIDTH, otherwise elaboration fails

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op valid
in_ready  output  1  unit can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  2  00 add, 01 sub, 10 adc, 11 sbb
cin  input  1  carry-in (adc) or borrow-in (sbb); ignored for op 00/01
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cf  output  1  carry-out (add/adc) or borrow-out (sub/sbb)
ovf  output  1  signed overflow
sf  output  1  sum[WIDTH-1]
zf  output  1  1 when sum == 0

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: in_ready=1, out_valid=0, sum=0, cf=0, ovf=0, sf=0, zf=0, FSM=IDLE, slice counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch a, b, op and cin, then go to BUSY.
  - The initial carry is 0 for add, 1 for sub, cin for adc, and ~cin for sbb.
- Operand B: B' = ~b for sub/sbb, b otherwise. The unit computes a + B' + initial carry.
- BUSY:
  - in_ready=0.
  - Each cycle, compute slice k (bits k*CHUNK .. k*CHUNK+CHUNK-1): a slice + B' slice + carry.
  - Store the result slice and carry the carry-out forward.
  - Accumulate a running OR of result bits for zf.
  - After slice N-1 (N=WIDTH/CHUNK), go to DONE.
- Latency: out_valid rises exactly N cycles after the accept edge. For WIDTH=16, CHUNK=4 that is 4 cycles.
- Flags at DONE:
  - cf = final carry-out XOR (op is sub or sbb). A 1 means borrow for subtraction.
  - ovf = (a[MSB]^sum[MSB]) & (B'[MSB]^sum[MSB]).
  - sf = sum[MSB].
  - zf = ~|sum.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and flags held stable while out_ready=0.
  - On out_ready=1, go to IDLE; out_valid drops next cycle and sum/flags keep their last values.
  - No back-to-back overlap: the next accept happens in IDLE, at the earliest one cycle after the result handshake.
- in_valid while not in IDLE is ignored. Latched operands are not affected by input changes during BUSY/DONE.
- CHUNK == WIDTH: N=1, so the result is valid 1 cycle after accept.
- Reset asserted mid-operation, in any state: immediate return to reset values; the partial result is discarded and out_valid is never raised for that operation.

Optional Feature:
ADDSUB_SAT_EN
- With the macro:
  - Adds input port sat (1 bit), latched with the operands.
  - If sat=1 and ovf=1, sum is clamped to the signed maximum (0111…1) when a[MSB]=0, or the signed minimum (1000…0) when a[MSB]=1.
  - sf and zf reflect the clamped sum.
  - cf and ovf report the raw, unclamped result.
  - Latency is unchanged.
- Without the macro: no sat port; sum is always the wrap-around result.

Test Plan:
- Add overflow: WIDTH=16, CHUNK=4, op=00, a=0x7FFF, b=0x0001, out_ready=1 → out_valid exactly 4 cycles after accept; sum=0x8000, cf=0, ovf=1, sf=1, zf=0.
- Subtract borrow and zero:
  - op=01, a=0x0000, b=0x0001 → sum=0xFFFF, cf=1, ovf=0, sf=1, zf=0.
  - Then a=0x1234, b=0x1234 → sum=0x0000, cf=0, zf=1.
- Carry chain:
  - op=10, a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cf=1, ovf=0, zf=1.
  - op=11, a=0x0000, b=0x0000, cin=1 → sum=0xFFFF, cf=1, sf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
  - Required: sum/flags stable, in_ready=0, new operands not taken.
  - After out_ready=1: return to IDLE, then the new operation is accepted.
- Reset mid-operation: assert rst_n=0 two cycles into BUSY → all outputs at reset values immediately.
  - After release: in_ready=1, out_valid=0.
  - A fresh op (0x0003+0x0004) gives sum=0x0007.
- Saturation (ADDSUB_SAT_EN defined):
  - sat=1, op=00, 0x7FFF+0x0001 → sum=0x7FFF, ovf=1, sf=0.
  - sat=1, op=01, 0x8000-0x0001 → sum=0x8000, ovf=1.
  - sat=0, op=00, 0x7FFF+0x0001 → sum=0x8000.
